// File: rtl/raptor64_shift_arb_pkg.sv
// Shared encodings for the raptor64 shifter arbiter: op codes, arbiter states, default widths.
// Pure definitions with no logic, so there is no latency and no backpressure.
package raptor64_shift_pkg;

  localparam int DATA_W         = 64;
  localparam int AMT_W          = 6;
  localparam int OP_W           = 3;
  localparam int TAGW_DEF       = 4;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [OP_W-1:0] {
    SH_SHL   = 3'd0,
    SH_SHRU  = 3'd1,
    SH_ROL   = 3'd2,
    SH_ROR   = 3'd3,
    SH_SHR   = 3'd4,
    SH_ROLAM = 3'd5
  } sh_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/raptor64_shift_arb_if.sv
// Request/grant/result bundle of the two-port shifter arbiter; master = requesters, slave = arbiter.
// Grants are combinational in the request cycle and results follow one cycle later, with no backpressure.
interface raptor64_shift_arb_if #(
  parameter int TAGW = raptor64_shift_pkg::TAGW_DEF
);
  import raptor64_shift_pkg::*;

  logic              req0_i, lock0_i, gnt0_o;
  logic [OP_W-1:0]   op0_i;
  logic [DATA_W-1:0] a0_i, mask0_i;
  logic [AMT_W-1:0]  amt0_i;
  logic [TAGW-1:0]   tag0_i;

  logic              req1_i, lock1_i, gnt1_o;
  logic [OP_W-1:0]   op1_i;
  logic [DATA_W-1:0] a1_i, mask1_i;
  logic [AMT_W-1:0]  amt1_i;
  logic [TAGW-1:0]   tag1_i;

  logic              rvld_o, rsel_o, busy_o;
  logic [TAGW-1:0]   rtag_o;
  logic [DATA_W-1:0] res_o;

  modport master (
    output req0_i, lock0_i, op0_i, a0_i, amt0_i, mask0_i, tag0_i,
    output req1_i, lock1_i, op1_i, a1_i, amt1_i, mask1_i, tag1_i,
    input  gnt0_o, gnt1_o, rvld_o, rsel_o, rtag_o, res_o, busy_o
  );

  modport slave (
    input  req0_i, lock0_i, op0_i, a0_i, amt0_i, mask0_i, tag0_i,
    input  req1_i, lock1_i, op1_i, a1_i, amt1_i, mask1_i, tag1_i,
    output gnt0_o, gnt1_o, rvld_o, rsel_o, rtag_o, res_o, busy_o
  );

endinterface

// File: rtl/raptor64_shift_core.sv
// Combinational 64-bit barrel shifter (SHL/SHRU/ROL/ROR/SHR/ROLAM); ops 6-7 give zero.
// Zero latency and no backpressure; the caller registers the output.
module raptor64_shift_core
  import raptor64_shift_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [AMT_W-1:0]  amt,
  input  logic [DATA_W-1:0] mask,
  output logic [DATA_W-1:0] o
);

  // A 7-bit complement lets amt=0 shift the wrap term by 64, which zeroes it.
  logic [AMT_W:0]    ramt;
  logic [DATA_W-1:0] rol, ror;

  assign ramt = 7'd64 - {1'b0, amt};
  assign rol  = (a << amt) | (a >> ramt);
  assign ror  = (a >> amt) | (a << ramt);

  always_comb begin
    o = '0;
    case (op)
      SH_SHL:   o = a << amt;
      SH_SHRU:  o = a >> amt;
      SH_ROL:   o = rol;
      SH_ROR:   o = ror;
      SH_SHR:   o = DATA_W'($signed(a) >>> amt);
      SH_ROLAM: o = rol & mask;
      default:  o = '0;
    endcase
  end

endmodule

// File: rtl/raptor64_shift_arb.sv
// Two-port arbiter for one barrel shifter: port 0 has priority, port 1 has a starvation guard, and either port can lock.
// Result is registered one cycle after the grant; requesters are stalled only by gnt; RAPTOR64_SHIFT_ARB_PERF_EN adds grant/starve counters.
module raptor64_shift_arb
  import raptor64_shift_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TAGW       = TAGW_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  raptor64_shift_arb_if.slave bus
`ifdef RAPTOR64_SHIFT_ARB_PERF_EN
  ,
  output logic [31:0] gnt_cnt0_o,
  output logic [31:0] gnt_cnt1_o,
  output logic [31:0] starve_evt_o
`endif
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              forced, gnt0, gnt1;
  logic [OP_W-1:0]   m_op;
  logic [DATA_W-1:0] m_a, m_mask, core_o;
  logic [AMT_W-1:0]  m_amt;
  logic              rvld_q, rsel_q;
  logic [TAGW-1:0]   rtag_q;
  logic [DATA_W-1:0] res_q;

  assign forced = (starve_q == CW'(STARVE_MAX));

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_i && !forced) gnt0 = 1'b1;
        else if (bus.req1_i)       gnt1 = 1'b1;
      end
      LOCK0:   gnt0 = bus.req0_i;
      LOCK1:   gnt1 = bus.req1_i;
      default: ;
    endcase
    // Grants are suppressed while reset is held so nothing is accepted then.
    if (!rst_i) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0)      state_d = bus.lock0_i ? LOCK0 : IDLE;
    else if (gnt1) state_d = bus.lock1_i ? LOCK1 : IDLE;
    if (state_q != LOCK0) begin
      if (gnt1 || !bus.req1_i)  starve_d = '0;
      else if (state_q == IDLE) starve_d = starve_q + 1'b1;
    end
  end

  assign m_op   = gnt1 ? bus.op1_i   : bus.op0_i;
  assign m_a    = gnt1 ? bus.a1_i    : bus.a0_i;
  assign m_amt  = gnt1 ? bus.amt1_i  : bus.amt0_i;
  assign m_mask = gnt1 ? bus.mask1_i : bus.mask0_i;

  raptor64_shift_core u_core (
    .op   (m_op),
    .a    (m_a),
    .amt  (m_amt),
    .mask (m_mask),
    .o    (core_o)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      starve_q <= '0;
      rvld_q   <= 1'b0;
      rsel_q   <= 1'b0;
      rtag_q   <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      rvld_q   <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        rsel_q <= gnt1;
        rtag_q <= gnt1 ? bus.tag1_i : bus.tag0_i;
        res_q  <= core_o;
      end
    end
  end

  assign bus.gnt0_o = gnt0;
  assign bus.gnt1_o = gnt1;
  assign bus.rvld_o = rvld_q;
  assign bus.rsel_o = rsel_q;
  assign bus.rtag_o = rtag_q;
  assign bus.res_o  = res_q;
  assign bus.busy_o = (state_q != IDLE);

`ifdef RAPTOR64_SHIFT_ARB_PERF_EN
  logic [31:0] cnt0_q, cnt1_q, sevt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
      sevt_q <= '0;
    end else begin
      if (gnt0 && cnt0_q != '1) cnt0_q <= cnt0_q + 32'd1;
      if (gnt1 && cnt1_q != '1) cnt1_q <= cnt1_q + 32'd1;
      if (gnt1 && forced && state_q == IDLE && sevt_q != '1) sevt_q <= sevt_q + 32'd1;
    end
  end

  assign gnt_cnt0_o   = cnt0_q;
  assign gnt_cnt1_o   = cnt1_q;
  assign starve_evt_o = sevt_q;
`endif

endmodule
